// File: rtl/montpro_pkg.sv
// Shared definitions for the Montgomery product cores and the exponentiator.
// Contents:
//   WID_DEF    - default operand/modulus width
//   CNTWID_DEF - default bit-counter width (2**CNTWID_DEF >= WID_DEF)
//   state_t    - state encoding used by the product cores
package montpro_pkg;

   localparam int WID_DEF    = 256;
   localparam int CNTWID_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOOP  = 2'd1,
      FINAL = 2'd2
   } state_t;

endpackage

// File: rtl/mod_csub.sv
// Conditional modular subtract: y = (x >= m) ? x - m : x.
// Purely combinational. Assumes x < 2*m, so one subtract brings the value
// into [0, m) and the result fits W bits.
// Ports:
//   x  in  W+1  value to reduce
//   m  in  W    modulus
//   y  out W    reduced value
module mod_csub #(
   parameter int W = 256
) (
   input  logic [W:0]   x,
   input  logic [W-1:0] m,
   output logic [W-1:0] y
);

   logic [W:0] m_ext;
   logic [W:0] diff;

   assign m_ext = {1'b0, m};
   assign diff  = x - m_ext;
   assign y     = (x >= m_ext) ? diff[W-1:0] : x[W-1:0];

endmodule

// File: rtl/montpro_serial.sv
// Bit-serial radix-2 Montgomery product: r = a*b*2^(-WID) mod m.
// One multiplier bit per cycle, fixed latency of WID+2 cycles from the start
// edge to the vld strobe, independent of operand values.
// Ports:
//   clk    in   1    clock
//   rst    in   1    synchronous active-high reset
//   a      in   WID  multiplicand (a < m)
//   b      in   WID  multiplier (b < m)
//   m      in   WID  odd modulus, m > 1
//   start  in   1    request pulse; a, b, m sampled on the same edge
//   r      out  WID  result, held until the next product completes
//   vld    out  1    one-cycle result strobe
//   busy   out  1    high while a product is in flight
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// LOOP  | one add/halve step per cycle, WID cycles
// FINAL | final conditional subtract, drive r and vld
module montpro_serial
   import montpro_pkg::*;
#(
   parameter int WID    = WID_DEF,
   parameter int CNTWID = CNTWID_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [WID-1:0] a,
   input  logic [WID-1:0] b,
   input  logic [WID-1:0] m,
   input  logic           start,
   output logic [WID-1:0] r,
   output logic           vld,
   output logic           busy
);

   state_t state, state_nxt;

   logic [CNTWID-1:0] cnt;
   logic [WID-1:0]    ra, rb, rm;
   logic [WID:0]      s;
   logic [WID:0]      s_nxt;
   logic [WID+1:0]    t, u;
   logic [WID-1:0]    r_fin;
   logic              last;

   assign last = (cnt == CNTWID'(WID - 1));
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOOP;
         LOOP:    if (last)  state_nxt = FINAL;
         FINAL:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ra is shifted right each step, so the current multiplicand bit is ra[0].
   // Sums are held WID+2 bits wide; s < 2*rm keeps the halved result in WID+1.
   always_comb begin
      t     = {1'b0, s} + (ra[0] ? {2'b00, rb} : '0);
      u     = t + (t[0] ? {2'b00, rm} : '0);
      s_nxt = u[WID+1:1];
   end

   mod_csub #(.W(WID)) u_csub (
      .x (s),
      .m (rm),
      .y (r_fin)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ra  <= '0;
         rb  <= '0;
         rm  <= '0;
         s   <= '0;
         cnt <= '0;
         r   <= '0;
         vld <= 1'b0;
      end else begin
         vld <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  ra  <= a;
                  rb  <= b;
                  rm  <= m;
                  s   <= '0;
                  cnt <= '0;
               end
            end
            LOOP: begin
               ra  <= ra >> 1;
               s   <= s_nxt;
               cnt <= cnt + CNTWID'(1);
            end
            FINAL: begin
               r   <= r_fin;
               vld <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/montpro_serial.md
# montpro_serial

Bit-serial radix-2 Montgomery product core computing r = a·b·2^(-WID) mod m. It sits directly downstream of the Montgomery exponentiator: each of that block's two product ports (mpa/mpb/mpstart → mpr/mpvld) drives one instance. Latency is fixed and data-independent, so two instances started in the same cycle assert vld in the same cycle.

## Interface
- WID, 256, operand/modulus width in bits
- CNTWID, 8, bit-counter width; must satisfy 2^CNTWID ≥ WID
- clk  input  1  clock
- rst  input  1  reset; **synchronous, active-high**
- a  input  WID  multiplicand; requires a < m
- b  input  WID  multiplier; requires b < m
- m  input  WID  modulus; requires m odd and m > 1
- start  input  1  one-cycle request pulse; a, b, m sampled on the same edge
- r  output  WID  result; reset 0
- vld  output  1  one-cycle result strobe; reset 0
- busy  output  1  high whenever state ≠ IDLE; reset 0

## Operation
- States: IDLE, LOOP, FINAL.
- IDLE and start:
  - Latch a → ra, b → rb, m → rm.
  - Clear the accumulator s (WID+1 bits) and cnt.
  - Go to LOOP.
- start while busy is ignored: no relatch and no effect on the running product.
- LOOP, once per cycle, with ai = ra[cnt]:
  - t = s + (ai ? rb : 0), held WID+2 bits wide.
  - q = t[0].
  - s ← (t + (q ? rm : 0)) >> 1.
  - cnt ← cnt + 1.
  - When cnt = WID-1, go to FINAL.
- Width rule:
  - The intermediate sum is held WID+2 bits; no truncation.
  - Invariant: s < 2·rm, which fits WID+1 bits.
- FINAL:
  - r ← (s ≥ rm) ? s − rm : s[WID-1:0].
  - vld ← 1.
  - Go to IDLE.
- r holds its value until the next FINAL. vld deasserts after one cycle.
- a = 0 or b = 0 gives r = 0. b = 1 gives a·2^(-WID) mod m, the domain-exit conversion.
- Inputs violating a < m, b < m or odd m give an undefined r but the same timing. No hang.

## Timing
- start sampled high in IDLE at edge k:
  - LOOP occupies cycles k+1 … k+WID.
  - FINAL is cycle k+WID+1.
  - vld is high in cycle k+WID+2.
  - Start-to-vld latency = WID+2 cycles, independent of data.
- State is IDLE in the vld cycle, so a start in that cycle is accepted (back-to-back). Throughput is one product per WID+2 cycles.
- a, b and m may change freely after the start edge.
- busy rises at edge k and falls at edge k+WID+2.
- rst at any edge, including mid-LOOP or FINAL:
  - Next cycle: state IDLE, vld 0, r 0, busy 0, cnt 0, s 0.
  - A pending product is discarded and produces no vld.
  - start coincident with rst is ignored.

## Structure
- Shared package montpro_pkg: WID/CNTWID defaults and the state encoding constants (IDLE=2'd0, LOOP=2'd1, FINAL=2'd2). The exponentiator uses the same package.
- One natural sub-module: mod_csub. It is combinational, WID+1 in → WID out, and computes the conditional subtract x ≥ m ? x − m : x. The modular adder elsewhere in the ECC datapath reuses it.
- Everything else stays in one module: FSM, cnt, ra/rb/rm/s registers, and the add/shift datapath.

## Test plan
- WID=8, m=13, a=5, b=7, start pulse → vld exactly 10 cycles later, r=1; vld high one cycle; r stays 1 afterwards.
- WID=8, m=255, a=254, b=254 → r=1; exercises s ≥ rm in FINAL. Also a=0, b=200 → r=0.
- WID=8, m=13:
  - a=1, b=1 → r=3.
  - a=12, b=12 → r=3.
  - A second start in the vld cycle of the first is accepted; its vld follows 10 cycles later.
- WID=8: start pulses during busy with different operands → ignored; original result unchanged and exactly one vld. rst asserted at LOOP cycle 4 → vld never rises, r=0, busy=0 next cycle; a new start then completes normally.
- WID=256: two instances started in the same cycle on random operands (a, b < m, m odd), checked against a Python model → both vld in the same cycle (258 cycles after start). Chained in the exponentiator, 3^5 mod a 256-bit prime matches the golden model.
